// File: rtl/bus_arbiter.sv
// bus_arbiter: single-outstanding arbiter of fetch and data requests onto one shared bus with a wait-timeout.
module bus_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        iready_n,
  output logic [31:0] idata,
  input  logic [1:0]  MemRW,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        dready_n,
  output logic [31:0] ddata,
  output logic        dbusy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);
  typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, DONE} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
  logic        iready_n_q, iready_n_d, dready_n_q, dready_n_d, dbusy_q, dbusy_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [31:0] idata_q, idata_d, ddata_q, ddata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        acc, tmo, fin, launch_w, launch_r, launch_f, launch;
  logic [31:0] rdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      iready_n_q  <= 1'b1;
      dready_n_q  <= 1'b1;
      dbusy_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      idata_q     <= '0;
      ddata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_err_q   <= bus_err_d;
      iready_n_q  <= iready_n_d;
      dready_n_q  <= dready_n_d;
      dbusy_q     <= dbusy_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      idata_q     <= idata_d;
      ddata_q     <= ddata_d;
    end
  always_comb begin
    acc      = state_q inside {FETCH, DREAD, DWRITE};
    tmo      = acc && !bus_ack && cnt_q == WAIT_LAST;
    fin      = acc && (bus_ack || tmo);
    launch_w = state_q == IDLE && MemRW[0];
    launch_r = state_q == IDLE && MemRW == 2'b10;
    launch_f = state_q == IDLE && MemRW == 2'b00 && i_req;
    launch   = launch_w || launch_r || launch_f;
    state_d  = launch_w ? DWRITE : launch_r ? DREAD : launch_f ? FETCH :
               fin ? DONE : state_q == DONE ? IDLE : state_q;
  end
  // Registered outputs are computed here so every completion pulse lands in the DONE cycle.
  always_comb begin
    rdata       = tmo ? 32'h0 : bus_rdata;
    cnt_d       = launch ? 8'h0 : (acc && !bus_ack) ? cnt_q + 8'h1 : cnt_q;
    bus_req_d   = launch ? 1'b1 : fin ? 1'b0 : bus_req_q;
    bus_we_d    = launch ? launch_w : fin ? 1'b0 : bus_we_q;
    bus_addr_d  = (launch_w || launch_r) ? d_addr : launch_f ? i_addr : bus_addr_q;
    bus_wdata_d = launch_w ? d_wdata : bus_wdata_q;
    bus_be_d    = launch_w ? d_be : (launch_r || launch_f) ? 4'hF : bus_be_q;
    idata_d     = (fin && state_q == FETCH) ? rdata : idata_q;
    ddata_d     = (fin && state_q == DREAD) ? rdata : ddata_q;
    iready_n_d  = !(fin && state_q == FETCH);
    dready_n_d  = !(fin && state_q == DREAD);
    bus_err_d   = tmo;
    dbusy_d     = launch_w ? 1'b1 : (fin && state_q == DWRITE) ? 1'b0 : dbusy_q;
  end
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_err   = bus_err_q;
  assign iready_n  = iready_n_q;
  assign dready_n  = dready_n_q;
  assign dbusy     = dbusy_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign idata     = idata_q;
  assign ddata     = ddata_q;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles an access waits for bus_ack before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  fetch request, held high until iready_n pulses low.
REQ-005 i_addr  input  32  fetch address, stable while i_req high.
REQ-006 iready_n  output  1  low for exactly one cycle when idata is valid.
REQ-007 idata  output  32  fetched instruction.
REQ-008 MemRW  input  2  data request: bit1 = read, bit0 = write, 00 = none.
REQ-009 d_addr, d_wdata  input  32 each  data address and store data.
REQ-010 d_be  input  4  store byte enables.
REQ-011 dready_n  output  1  low for exactly one cycle when ddata is valid (read completion).
REQ-012 ddata  output  32  load data.
REQ-013 dbusy  output  1  high while a store is outstanding.
REQ-014 bus_req, bus_we  output  1 each  shared-bus request and write strobe.
REQ-015 bus_addr, bus_wdata  output  32 each  latched address and store data.
REQ-016 bus_be  output  4  latched byte enables; 4'hF on reads.
REQ-017 bus_ack  input  1  slave completion, sampled on the rising edge.
REQ-018 bus_rdata  input  32  read data, valid in the bus_ack cycle.
REQ-019 bus_err  output  1  one-cycle pulse on timeout.

Function
REQ-020 FSM states: IDLE, FETCH, DREAD, DWRITE, DONE; one access in flight at a time.
REQ-021 IDLE launch priority: data over fetch; MemRW = 2'b11 is treated as a write; fetch launches only when MemRW = 00.
REQ-022 On launch, latch addr/wdata/be into the bus_* registers and assert bus_req from the next cycle; bus_we = 1 only in DWRITE.
REQ-023 bus_req and bus_* outputs hold constant until bus_ack is sampled high or a timeout occurs.
REQ-024 bus_ack in FETCH/DREAD: capture bus_rdata into idata/ddata and go to DONE; bus_req drops in the DONE cycle.
REQ-025 DONE lasts exactly one cycle: pulse the matching ready_n low (iready_n or dready_n; none for a write), then return to IDLE; no launch occurs from DONE.
REQ-026 dbusy rises the cycle after a write launch and falls in the DONE cycle following that write's ack.
REQ-027 Minimum latency: request in IDLE at cycle N, bus_req at N+1, ack at N+1, ready_n low at N+2.
REQ-028 Wait counter (8 bit) clears on launch and increments every access-state cycle without ack.
REQ-029 If the counter reaches MAX_WAIT with no ack: drop bus_req, pulse bus_err, enter DONE, and return 32'h0 as data (ready_n still pulses).
REQ-030 bus_ack while in IDLE or DONE is ignored.
REQ-031 A request deasserted mid-access does not abort the bus cycle; the access completes and its ready pulse is still issued.
REQ-032 idata/ddata hold their last value until the next completion of the same type.

Reset
REQ-033 While rst is low, immediately: state = IDLE, bus_req = 0, bus_we = 0, bus_err = 0, dbusy = 0, iready_n = 1, dready_n = 1.
REQ-034 While rst is low, immediately: bus_addr, bus_wdata, idata, ddata, and the counter = 0; bus_be = 0.
REQ-035 Reset asserted mid-access abandons the access with no ready pulse; bus_req falls asynchronously.

Verification
REQ-036 Fetch: i_req=1, i_addr=0x100, ack after 2 wait cycles with rdata=0x00000013 -> bus_addr=0x100, iready_n low for exactly one cycle, idata=0x13.
REQ-037 Conflict: i_req=1 and MemRW=10 in the same IDLE cycle -> data read served first, fetch launched after DONE, two distinct ready pulses.
REQ-038 Store: MemRW=01, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> bus_we=1, dbusy high until DONE, no dready_n pulse.
REQ-039 Timeout: MAX_WAIT=4, no ack -> bus_req high for 4 cycles, then bus_err pulse, ddata=0, dready_n pulse.
REQ-040 Reset mid-DREAD -> bus_req 0 within the reset cycle, all outputs at reset values, normal fetch after release.
